// File: rtl/cpu_run_pkg.sv
// Shared state encodings and LED view selectors for the CPU run monitor.
// Pure declarations, no logic or latency of its own.
package cpu_run_pkg;

  typedef enum logic [1:0] {
    RS_HOLD    = 2'd0,
    RS_RUN     = 2'd1,
    RS_HALTED  = 2'd2,
    RS_TIMEOUT = 2'd3
  } run_state_e;

  localparam logic [1:0] ST_HOLD    = RS_HOLD;
  localparam logic [1:0] ST_RUN     = RS_RUN;
  localparam logic [1:0] ST_HALTED  = RS_HALTED;
  localparam logic [1:0] ST_TIMEOUT = RS_TIMEOUT;

  localparam logic [1:0] LED_VIEW_PC_LO  = 2'd0;
  localparam logic [1:0] LED_VIEW_PC_HI  = 2'd1;
  localparam logic [1:0] LED_VIEW_CYCLES = 2'd2;
  localparam logic [1:0] LED_VIEW_STATUS = 2'd3;

  // Stable counter only has to reach window-1, so clog2(window) bits suffice.
  function automatic int stable_width(input int window);
    return $clog2(window);
  endfunction

endpackage

// File: rtl/pc_halt_detect.sv
// Tracks the last valid PC and counts back-to-back repeats of it.
// halt_hit is combinational on the sample that completes the window; no backpressure.
module pc_halt_detect
  import cpu_run_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int HALT_WINDOW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [PC_WIDTH-1:0] pc_in,
  input  logic                pc_valid,
  output logic [PC_WIDTH-1:0] last_pc,
  output logic                halt_hit
);

  localparam int SW = stable_width(HALT_WINDOW);

  logic [SW-1:0] stable;
  logic          take;
  logic          sample_eq;

  assign take      = en & pc_valid;
  assign sample_eq = (pc_in == last_pc);
  // The sample that lifts the counter to window-1 is the one that declares the halt.
  assign halt_hit  = take & sample_eq & (stable == SW'(HALT_WINDOW - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pc <= '0;
      stable  <= '0;
    end else if (take) begin
      last_pc <= pc_in;
      stable  <= sample_eq ? stable + 1'b1 : '0;
    end
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Holds the core in reset, runs it, and freezes it on self-loop halt or cycle-budget timeout.
// Status flags change on the transition edge; led_pc lags its sources by one cycle; no backpressure.
module cpu_run_monitor
  import cpu_run_pkg::*;
#(
  parameter int PC_WIDTH     = 32,
  parameter int LED_WIDTH    = 16,
  parameter int CNT_WIDTH    = 32,
  parameter int RESET_CYCLES = 52,
  parameter int HALT_WINDOW  = 8,
  parameter int MAX_CYCLES   = 5000
) (
  input  logic                 clk_init,
  input  logic                 rst_init,
  input  logic [PC_WIDTH-1:0]  pc_in,
  input  logic                 pc_valid,
  input  logic [1:0]           led_sel,
  output logic                 cpu_rst_n,
  output logic                 running,
  output logic                 halted,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [PC_WIDTH-1:0]  last_pc,
  output logic [LED_WIDTH-1:0] led_pc
);

  localparam int HOLD_W   = $clog2(RESET_CYCLES) + 1;
  localparam int PC_EXT_W = (PC_WIDTH > 2 * LED_WIDTH) ? PC_WIDTH : 2 * LED_WIDTH;

  logic [1:0]           state;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 run_en;
  logic                 halt_hit;
  logic [PC_EXT_W-1:0]  pc_ext;
  logic [LED_WIDTH-1:0] led_nxt;

  assign run_en  = (state == ST_RUN);
  assign cnt_inc = cycle_count + 1'b1;

  pc_halt_detect #(
    .PC_WIDTH    (PC_WIDTH),
    .HALT_WINDOW (HALT_WINDOW)
  ) u_halt (
    .clk      (clk_init),
    .rst_n    (rst_init),
    .en       (run_en),
    .pc_in    (pc_in),
    .pc_valid (pc_valid),
    .last_pc  (last_pc),
    .halt_hit (halt_hit)
  );

  // Zero-extend so the high LED view reads zeros when the PC is narrower than two LED words.
  always_comb begin
    pc_ext                 = '0;
    pc_ext[PC_WIDTH-1:0]   = last_pc;
  end

  always_comb begin
    led_nxt = '0;
    case (led_sel)
      LED_VIEW_PC_LO:  led_nxt = pc_ext[LED_WIDTH-1:0];
      LED_VIEW_PC_HI:  led_nxt = pc_ext[2*LED_WIDTH-1:LED_WIDTH];
      LED_VIEW_CYCLES: led_nxt = cycle_count[LED_WIDTH-1:0];
      LED_VIEW_STATUS: begin
        led_nxt[1:0] = state;
        led_nxt[2]   = halted;
        led_nxt[3]   = timeout;
      end
    endcase
  end

  always_ff @(posedge clk_init or negedge rst_init) begin
    if (!rst_init) begin
      state       <= ST_HOLD;
      hold_cnt    <= '0;
      cycle_count <= '0;
      cpu_rst_n   <= 1'b0;
      running     <= 1'b0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      led_pc      <= '0;
    end else begin
      led_pc <= led_nxt;
      case (state)
        ST_HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
            state     <= ST_RUN;
            cpu_rst_n <= 1'b1;
            running   <= 1'b1;
          end
        end
        ST_RUN: begin
          cycle_count <= cnt_inc;
          // Halt takes priority when both events land on the same edge.
          if (halt_hit) begin
            state     <= ST_HALTED;
            halted    <= 1'b1;
            cpu_rst_n <= 1'b0;
            running   <= 1'b0;
          end else if (cnt_inc == CNT_WIDTH'(MAX_CYCLES)) begin
            state     <= ST_TIMEOUT;
            timeout   <= 1'b1;
            cpu_rst_n <= 1'b0;
            running   <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
